// File: rtl/bsg_link_osdr_pkg.sv
`default_nettype none
// ============================================================================
// Package : bsg_link_osdr_pkg
// Brief   : Shared state encoding and PRBS7 helpers for the trainable OSDR PHY.
// Rev     : 1.0
// ============================================================================
package bsg_link_osdr_pkg;

  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TRAIN   = 2'd2,
    ST_PATTERN = 2'd3
  } bsg_link_osdr_state_e;

  // x^7 + x^6 + 1: feedback taps are s[6] and s[5]
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  function automatic logic [6:0] prbs7_seed(input int unsigned c);
    prbs7_seed = 7'((c % 127) + 1);
  endfunction

  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    prbs7_next = {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_link_osdr_clk_fwd.sv
`default_nettype none
// ============================================================================
// Module : bsg_link_osdr_clk_fwd
// Brief  : Posedge/negedge flop pair producing a glitch-free forwarded clock.
// Rev    : 1.0
// ============================================================================
module bsg_link_osdr_clk_fwd (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic clk_o
);

  logic p_q;
  logic n_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   p_q <= 1'b0;
    else if (en_i) p_q <= ~p_q;
  end

  // n_q catches up with p_q half a cycle later, so every pulse is a full high phase
  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) n_q <= 1'b0;
    else         n_q <= p_q;
  end

  assign clk_o = p_q ^ n_q;

endmodule
`default_nettype wire

// File: rtl/bsg_link_osdr_phy_trainable.sv
`default_nettype none
// ============================================================================
// Module : bsg_link_osdr_phy_trainable
// Brief  : Multi-channel SDR output PHY with clock stop, PRBS7 training and
//          fixed toggle pattern modes.
// Rev    : 1.0
// ============================================================================
module bsg_link_osdr_phy_trainable
  import bsg_link_osdr_pkg::*;
#(
  parameter int channels_p  = 2,
  parameter int width_p     = 8,
  parameter int train_len_p = 1024
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          cmd_v_i,
  input  logic [1:0]                    cmd_i,
  output logic                          cmd_ready_o,
  input  logic [channels_p*width_p-1:0] data_i,
  output logic                          train_done_o,
  output logic [1:0]                    state_o,
  output logic [channels_p-1:0]         clk_o,
  output logic [channels_p*width_p-1:0] data_o
);

  localparam logic [15:0] TRAIN_LOAD = 16'(train_len_p - 1);

  bsg_link_osdr_state_e state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 phase_q, phase_d;
  logic                 train_entry;
  logic                 fwd_clk;

  assign cmd_ready_o  = (state_q != ST_TRAIN);
  assign train_done_o = done_q;
  assign state_o      = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    phase_d     = phase_q;
    train_entry = 1'b0;
    if (state_q == ST_TRAIN) begin
      if (cnt_q == '0) begin
        state_d = ST_RUN;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end else if (cmd_v_i) begin
      state_d = bsg_link_osdr_state_e'(cmd_i);
    end
    train_entry = (state_q != ST_TRAIN) && (state_d == ST_TRAIN);
    if (train_entry) cnt_d = TRAIN_LOAD;
    // re-issuing PATTERN keeps the running phase; entering from elsewhere restarts at 0x55
    if (state_q == ST_PATTERN)      phase_d = ~phase_q;
    else if (state_d == ST_PATTERN) phase_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      phase_q <= phase_d;
    end
  end

  bsg_link_osdr_clk_fwd u_clk_fwd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (state_q != ST_STOP),
    .clk_o   (fwd_clk)
  );

  assign clk_o = {channels_p{fwd_clk}};

  for (genvar c = 0; c < channels_p; c++) begin : g_chan
    localparam logic [6:0] SEED = prbs7_seed(c);

    logic [6:0]         lfsr_q;
    logic [width_p-1:0] prbs_bits;
    logic [width_p-1:0] pat_bits;
    logic [width_p-1:0] chan_q;

    for (genvar j = 0; j < width_p; j++) begin : g_bit
      assign prbs_bits[j] = lfsr_q[j % 7];
      assign pat_bits[j]  = phase_q ^ ((j % 2) == 0);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                    lfsr_q <= SEED;
      else if (train_entry)           lfsr_q <= SEED;
      else if (state_q == ST_TRAIN)   lfsr_q <= prbs7_next(lfsr_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        chan_q <= '0;
      end else begin
        case (state_q)
          ST_RUN:     chan_q <= data_i[c*width_p +: width_p];
          ST_TRAIN:   chan_q <= prbs_bits;
          ST_PATTERN: chan_q <= pat_bits;
          default:    chan_q <= chan_q;
        endcase
      end
    end

    assign data_o[c*width_p +: width_p] = chan_q;
  end

endmodule
`default_nettype wire

// File: doc/bsg_link_osdr_phy_trainable.md
# bsg_link_osdr_phy_trainable

Multi-channel output single-data-rate PHY for the bsg_link transmit side. It registers `channels_p` × `width_p` data bits and forwards a source-synchronous clock per channel. It adds two things: a glitch-free forwarded-clock stop, and a built-in line-training mode (a timed PRBS7 burst, or a fixed toggle pattern). The block sits between the link upstream serializer and the pad ring.

## Interface
- `channels_p`, default 2: number of independent output channels.
- `width_p`, default 8: data bits per channel.
- `train_len_p`, default 1024: cycles per PRBS training burst, range 1..2^16.
- `clk_i` input 1: core/transmit clock; all state is on its rising edge except the negedge clock flop.
- `reset_i` input 1: asynchronous, active-high reset.
- `cmd_v_i` input 1: command valid.
- `cmd_i` input 2: 0=STOP, 1=RUN, 2=TRAIN, 3=PATTERN.
- `cmd_ready_o` output 1: command accepted this cycle when `cmd_v_i & cmd_ready_o`.
- `data_i` input channels_p*width_p: payload; channel c occupies `[c*width_p +: width_p]`.
- `train_done_o` output 1: one-cycle pulse at the end of a TRAIN burst.
- `state_o` output 2: current state encoding.
- `clk_o` output channels_p: forwarded clock, one per channel, all identical.
- `data_o` output channels_p*width_p: registered line data.

## Operation
- **States and encoding:** STOP=0, RUN=1, TRAIN=2, PATTERN=3. Reset enters STOP.
- **Command handshake:**
  - `cmd_ready_o` is 1 in every state except TRAIN.
  - An accepted command moves the state to the commanded state at the next edge.
  - In TRAIN, commands are ignored and not consumed.
- **TRAIN:**
  - Counter loads `train_len_p-1` on entry and decrements once per cycle.
  - At count 0, the block returns to RUN and pulses `train_done_o` together with the transition edge.
  - The pulse is registered, so it is visible the cycle after the last TRAIN cycle.
- **Clock forwarding:** per-block flop pair, replicated to each `clk_o` bit.
  - Flop `p_r` (posedge) toggles when `state != STOP`.
  - Flop `n_r` (negedge) captures `p_r`.
  - `clk_o = p_r ^ n_r`.
  - Forwarded clock is `clk_i` delayed by one clock-to-Q, high from posedge to the following negedge.
  - In STOP, `p_r` holds, so `clk_o` settles low at the next negedge. No runt pulse is allowed.
- **Data source per state** (registered, 1 cycle):
  - STOP: data_o holds its last value.
  - RUN: `data_i`.
  - TRAIN: PRBS7 per channel.
  - PATTERN: width_p-bit alternating 0x55…/0xAA… per channel, flipping every cycle and starting with 0x55 on entry.
- **PRBS7:**
  - Each channel has a 7-bit LFSR with polynomial x^7+x^6+1, Fibonacci form; new bit0 = s[6]^s[5], shifted left.
  - Seed for channel c is `(c mod 127)+1`. It is reloaded on every TRAIN entry and advances once per TRAIN cycle.
  - data_o bit j of channel c = `lfsr_c[j mod 7]`.
- **Reset mid-operation:** asynchronous assertion forces all outputs to their reset values immediately; no training completion is reported.

## Timing
- **Reset values:** `clk_o`=0, `data_o`=0, `state_o`=STOP, `cmd_ready_o`=1, `train_done_o`=0, `p_r`=`n_r`=0, LFSRs=seeds.
- **Data latency:** `data_i` at edge k appears on `data_o` after edge k+1, valid while state is RUN.
- **Command latency:** command accepted at edge k, new state effective from edge k+1.
  - The first data_o of the new source appears after edge k+2.
  - The first forwarded clock pulse after leaving STOP rises at edge k+2.
- **TRAIN duration:** exactly `train_len_p` cycles of PRBS data on `data_o`.
- **Back-to-back commands:** the same command is idempotent. The exception is TRAIN, which is never re-accepted while already training because ready is 0.

## Structure
- Shared package `bsg_link_osdr_pkg`: state/command enum (`bsg_link_osdr_state_e`), PRBS7 polynomial constant, and seed function.
- One sub-module `bsg_link_osdr_clk_fwd` holds the posedge/negedge flop pair and XOR. It is hand-instantiated with dont-touch cells for timing control.
- Top-level holds the FSM, train counter, LFSR array (generate over channels), and data mux/registers.

## Test plan
- **Reset:** assert `reset_i` mid-cycle -> all outputs 0 and state STOP immediately; `clk_o` flat for 5 cycles.
- **RUN:** cmd RUN, then `data_i`=0xA5_3C -> `data_o`=0xA5_3C one edge later; `clk_o` toggles every cycle with no gap.
- **TRAIN:** `train_len_p`=8; cmd TRAIN.
  - Channel 0 emits a PRBS7 sequence from seed 0x01 and channel 1 from seed 0x02 for exactly 8 cycles.
  - `cmd_ready_o`=0 throughout and `train_done_o` pulses once; state returns to RUN.
  - A RUN cmd presented during TRAIN is not consumed.
- **PATTERN:** cmd PATTERN -> `data_o` alternates 0x55/0xAA per channel, starting 0x55.
- **STOP glitch check:** cmd STOP issued both just before and just after a negedge -> `clk_o` completes its current high phase and no pulse narrower than half a period occurs; `data_o` holds.
- **Reset during TRAIN:** reset at count 3 -> no `train_done_o`; after release, state STOP and LFSRs at seed.
